// File: rtl/apb2axi_pkg.sv
// Shared types and AXI constants for the APB-to-AXI bridge master engine.
// Struct widths follow the package defaults; keep module parameters in step with them.
package apb2axi_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_LEN_W  = 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef struct packed {
    logic                  is_wr;
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
    logic [2:0]            size;
  } cmd_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
  } wd_t;

  typedef struct packed {
    logic                  is_wr;
    logic [AXI_ID_W-1:0]   id;
    logic [1:0]            resp;
    logic [AXI_DATA_W-1:0] data;
    logic                  last;
    logic                  len_err;
  } rsp_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_WRSP = 3'd6
  } state_t;

endpackage

// File: rtl/apb2axi_axi_master_fsm_if.sv
// AXI4 read/write channel bundle between the bridge master engine and the AXI slave.
interface apb2axi_axi_master_fsm_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned LEN_W  = 8
);
  logic              awvalid, awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic                wvalid, wready, wlast;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;

  logic            bvalid, bready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;

  logic              arvalid, arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid, rready, rlast;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input bvalid, bid, bresp, output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, input arready,
    input rvalid, rid, rdata, rresp, rlast, output rready
  );

  modport slave (
    input awvalid, awid, awaddr, awlen, awsize, awburst, output awready,
    input wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bid, bresp, input bready,
    input arvalid, arid, araddr, arlen, arsize, arburst, output arready,
    output rvalid, rid, rdata, rresp, rlast, input rready
  );
endinterface

// File: rtl/apb2axi_axi_master_fsm.sv
// AXI4 master engine: pops one command, runs one burst, emits response entries in order.
// Optional performance counters are enabled by defining APB2AXI_PERF_CNT_EN.
module apb2axi_axi_master_fsm
  import apb2axi_pkg::*;
#(
  parameter int unsigned ADDR_W = AXI_ADDR_W,
  parameter int unsigned DATA_W = AXI_DATA_W,
  parameter int unsigned ID_W   = AXI_ID_W,
  parameter int unsigned LEN_W  = AXI_LEN_W
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd_vld,
  output logic cmd_rdy,
  input  cmd_t cmd_data,
  input  logic wd_vld,
  output logic wd_rdy,
  input  wd_t  wd_data,
  apb2axi_axi_master_fsm_if.master axi,
  output logic rsp_vld,
  input  logic rsp_rdy,
  output rsp_t rsp_data
`ifdef APB2AXI_PERF_CNT_EN
  ,
  output logic [31:0] perf_wr_cnt,
  output logic [31:0] perf_rd_cnt,
  output logic [15:0] perf_err_cnt
`endif
);

  state_t            state, state_nxt;
  logic              cmd_rdy_q;
  logic              is_wr_q;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [2:0]        size_q;
  logic [LEN_W:0]    beat_cnt;
  logic [1:0]        bresp_q;
  logic              bid_err_q;
  logic              cmd_hs, w_hs, r_hs, last_beat, r_len_err;

  assign cmd_rdy   = cmd_rdy_q;
  assign cmd_hs    = cmd_vld & cmd_rdy_q;
  assign w_hs      = axi.wvalid & axi.wready;
  assign r_hs      = axi.rvalid & axi.rready;
  assign last_beat = (beat_cnt == {1'b0, len_q});
  // Beats past len (short of rlast) are errors as well as a misplaced rlast.
  assign r_len_err = (beat_cnt > {1'b0, len_q}) | (axi.rlast != last_beat);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_hs) state_nxt = cmd_data.is_wr ? ST_AW : ST_AR;
      ST_AW:   if (axi.awready) state_nxt = ST_W;
      ST_W:    if (w_hs && axi.wlast) state_nxt = ST_B;
      ST_B:    if (axi.bvalid) state_nxt = ST_WRSP;
      ST_WRSP: if (rsp_rdy) state_nxt = ST_IDLE;
      ST_AR:   if (axi.arready) state_nxt = ST_R;
      ST_R:    if (r_hs && axi.rlast) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // cmd_rdy is registered so it stays low through reset and rises one cycle after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd_rdy_q <= 1'b0;
      is_wr_q   <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      beat_cnt  <= '0;
      bresp_q   <= AXI_RESP_OKAY;
      bid_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_rdy_q <= (state_nxt == ST_IDLE);
      if (cmd_hs) begin
        is_wr_q <= cmd_data.is_wr;
        id_q    <= cmd_data.id;
        addr_q  <= cmd_data.addr;
        len_q   <= cmd_data.len;
        size_q  <= cmd_data.size;
      end
      if ((state == ST_AW && axi.awready) || (state == ST_AR && axi.arready))
        beat_cnt <= '0;
      else if (w_hs || (r_hs && !(&beat_cnt)))
        beat_cnt <= beat_cnt + (LEN_W+1)'(1);
      if (state == ST_B && axi.bvalid) begin
        bresp_q   <= axi.bresp;
        bid_err_q <= (axi.bid != id_q);
      end
    end
  end

  always_comb begin
    axi.awvalid = (state == ST_AW);
    axi.awid    = id_q;
    axi.awaddr  = addr_q;
    axi.awlen   = len_q;
    axi.awsize  = size_q;
    axi.awburst = AXI_BURST_INCR;
    axi.arvalid = (state == ST_AR);
    axi.arid    = id_q;
    axi.araddr  = addr_q;
    axi.arlen   = len_q;
    axi.arsize  = size_q;
    axi.arburst = AXI_BURST_INCR;
    axi.wvalid  = (state == ST_W) & wd_vld;
    wd_rdy      = (state == ST_W) & axi.wready;
    axi.wdata   = wd_data.data[DATA_W-1:0];
    axi.wstrb   = wd_data.strb;
    axi.wlast   = (state == ST_W) & last_beat;
    axi.bready  = (state == ST_B);
    axi.rready  = (state == ST_R) & rsp_rdy;
    rsp_vld     = 1'b0;
    rsp_data    = '0;
    if (state == ST_WRSP) begin
      rsp_vld          = 1'b1;
      rsp_data.is_wr   = is_wr_q;
      rsp_data.id      = id_q;
      rsp_data.resp    = bresp_q;
      rsp_data.last    = 1'b1;
      rsp_data.len_err = bid_err_q;
    end else if (state == ST_R) begin
      rsp_vld          = axi.rvalid;
      rsp_data.id      = axi.rid;
      rsp_data.resp    = axi.rresp;
      rsp_data.data    = axi.rdata;
      rsp_data.last    = axi.rlast;
      rsp_data.len_err = r_len_err;
    end
  end

`ifdef APB2AXI_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_wr_cnt  <= '0;
      perf_rd_cnt  <= '0;
      perf_err_cnt <= '0;
    end else begin
      if (state == ST_WRSP && rsp_rdy && !(&perf_wr_cnt))
        perf_wr_cnt <= perf_wr_cnt + 32'd1;
      if (r_hs && axi.rlast && !(&perf_rd_cnt))
        perf_rd_cnt <= perf_rd_cnt + 32'd1;
      if (rsp_vld && rsp_rdy && (rsp_data.resp != AXI_RESP_OKAY || rsp_data.len_err)
          && !(&perf_err_cnt))
        perf_err_cnt <= perf_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_apb2axi_axi_master_fsm.sv
// Scoreboard bench for apb2axi_axi_master_fsm: directed writes/reads, mid-burst reset, perf counters.
module tb_apb2axi_axi_master_fsm;
  import apb2axi_pkg::*;

  typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; } a_exp_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } w_exp_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_plan_t;
  typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_plan_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic cmd_vld, cmd_rdy, wd_vld, wd_rdy, rsp_vld, rsp_rdy;
  cmd_t cmd_data;
  wd_t  wd_data;
  rsp_t rsp_data;
`ifdef APB2AXI_PERF_CNT_EN
  logic [31:0] perf_wr_cnt, perf_rd_cnt;
  logic [15:0] perf_err_cnt;
`endif

  apb2axi_axi_master_fsm_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .LEN_W(8)) axi ();

  apb2axi_axi_master_fsm #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .LEN_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_data(cmd_data),
    .wd_vld(wd_vld), .wd_rdy(wd_rdy), .wd_data(wd_data),
    .axi(axi),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data)
`ifdef APB2AXI_PERF_CNT_EN
    , .perf_wr_cnt(perf_wr_cnt), .perf_rd_cnt(perf_rd_cnt), .perf_err_cnt(perf_err_cnt)
`endif
  );

  cmd_t    cmd_q[$];
  wd_t     wd_q[$];
  a_exp_t  aw_exp[$], ar_exp[$];
  w_exp_t  w_exp[$];
  rsp_t    rsp_exp[$];
  b_plan_t b_plan[$];
  r_plan_t r_plan[$];

  int checks = 0, failures = 0;
  int w_seen = 0, rsp_seen = 0, hold_seen = 0, r_acc = 0, hold_at = -1, hold_cnt = 0;
  logic wd_gap = 1'b0, phase = 1'b0, b_arm = 1'b0, r_arm = 1'b0;
  logic hs_cmd, hs_wd, hs_wl, hs_b, hs_ar, hs_r, hs_rl;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got handshake required none (expectation queue empty)", name);
  endtask

  task automatic push_wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [31:0] dbase, input logic [1:0] resp, input logic [3:0] bid,
                         input logic err);
    cmd_t c;
    wd_t w;
    rsp_t r;
    a_exp_t a;
    c = '{is_wr: 1'b1, id: id, addr: addr, len: len, size: 3'd2};
    a = '{id: id, addr: addr, len: len, size: 3'd2};
    aw_exp.push_back(a);
    for (int i = 0; i <= int'(len); i++) begin
      w.data = dbase + 32'(i);
      w.strb = (i == 0) ? 4'hF : (4'(i) ^ 4'hF);
      wd_q.push_back(w);
      w_exp.push_back('{data: w.data, strb: w.strb, last: (i == int'(len))});
    end
    b_plan.push_back('{id: bid, resp: resp});
    r = '{is_wr: 1'b1, id: id, resp: resp, data: 32'h0, last: 1'b1, len_err: err};
    rsp_exp.push_back(r);
    cmd_q.push_back(c);
  endtask

  task automatic push_rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input int nbeats, input logic [31:0] dbase, input logic [1:0] resp,
                         input logic [7:0] err_mask);
    cmd_t c;
    rsp_t r;
    a_exp_t a;
    c = '{is_wr: 1'b0, id: id, addr: addr, len: len, size: 3'd2};
    a = '{id: id, addr: addr, len: len, size: 3'd2};
    ar_exp.push_back(a);
    for (int k = 0; k < nbeats; k++) begin
      r_plan.push_back('{id: id, data: dbase + 32'(k), resp: resp, last: (k == nbeats - 1)});
      r = '{is_wr: 1'b0, id: id, resp: resp, data: dbase + 32'(k), last: (k == nbeats - 1),
            len_err: err_mask[k]};
      rsp_exp.push_back(r);
    end
    cmd_q.push_back(c);
  endtask

  task automatic wait_rsp(input int target, input string name);
    int n = 0;
    while (rsp_seen < target && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (rsp_seen < target) begin
      failures++;
      $display("FAIL %s timeout: got %0d responses required %0d", name, rsp_seen, target);
    end
  endtask

  task automatic clear_queues();
    cmd_q.delete(); wd_q.delete(); aw_exp.delete(); ar_exp.delete();
    w_exp.delete(); rsp_exp.delete(); b_plan.delete(); r_plan.delete();
  endtask

  // AXI slave, command/write-data sources and response sink
  initial begin
    cmd_vld = 1'b0; cmd_data = '0; wd_vld = 1'b0; wd_data = '0; rsp_rdy = 1'b1;
    axi.awready = 1'b1; axi.wready = 1'b1; axi.arready = 1'b1;
    axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = '0;
    axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
    forever begin
      @(negedge clk);
      hs_cmd = cmd_vld & cmd_rdy;
      hs_wd  = wd_vld & wd_rdy;
      hs_wl  = axi.wvalid & axi.wready & axi.wlast;
      hs_b   = axi.bvalid & axi.bready;
      hs_ar  = axi.arvalid & axi.arready;
      hs_r   = axi.rvalid & axi.rready;
      hs_rl  = axi.rlast;
      @(posedge clk); #1;
      if (reset) begin
        b_arm = 1'b0; r_arm = 1'b0; hold_cnt = 0;
      end else begin
        if (hs_cmd && cmd_q.size() > 0) void'(cmd_q.pop_front());
        if (hs_wd && wd_q.size() > 0) void'(wd_q.pop_front());
        if (hs_wl) b_arm = 1'b1;
        if (hs_b) begin
          b_arm = 1'b0;
          if (b_plan.size() > 0) void'(b_plan.pop_front());
        end
        if (hs_ar) r_arm = 1'b1;
        if (hs_r) begin
          if (hs_rl) r_arm = 1'b0;
          if (r_plan.size() > 0) void'(r_plan.pop_front());
          r_acc++;
          if (r_acc == hold_at) hold_cnt = 5;
        end
      end
      phase = ~phase;
      if (hold_cnt > 0) begin
        rsp_rdy = 1'b0;
        hold_cnt--;
      end else rsp_rdy = 1'b1;
      cmd_vld  = (cmd_q.size() > 0);
      cmd_data = (cmd_q.size() > 0) ? cmd_q[0] : '0;
      wd_vld   = (wd_q.size() > 0) && (!wd_gap || phase);
      wd_data  = (wd_q.size() > 0) ? wd_q[0] : '0;
      axi.bvalid = b_arm && (b_plan.size() > 0);
      axi.bid    = (b_plan.size() > 0) ? b_plan[0].id : '0;
      axi.bresp  = (b_plan.size() > 0) ? b_plan[0].resp : '0;
      axi.rvalid = r_arm && (r_plan.size() > 0);
      axi.rid    = (r_plan.size() > 0) ? r_plan[0].id : '0;
      axi.rdata  = (r_plan.size() > 0) ? r_plan[0].data : '0;
      axi.rresp  = (r_plan.size() > 0) ? r_plan[0].resp : '0;
      axi.rlast  = (r_plan.size() > 0) ? r_plan[0].last : 1'b0;
    end
  end

  // Monitor: pops expectations whenever the DUT completes a handshake
  initial begin
    a_exp_t a;
    w_exp_t w;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (axi.awvalid && axi.awready) begin
          if (aw_exp.size() == 0) unexpected("aw");
          else begin
            a = aw_exp.pop_front();
            check("aw_fields", {axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst},
                  {a.id, a.addr, a.len, a.size, 2'b01});
          end
        end
        if (axi.arvalid && axi.arready) begin
          if (ar_exp.size() == 0) unexpected("ar");
          else begin
            a = ar_exp.pop_front();
            check("ar_fields", {axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst},
                  {a.id, a.addr, a.len, a.size, 2'b01});
          end
        end
        if (axi.wvalid) check("wvalid_needs_wd_vld", wd_vld, 1'b1);
        if (axi.wvalid && axi.wready) begin
          w_seen++;
          if (w_exp.size() == 0) unexpected("w");
          else begin
            w = w_exp.pop_front();
            check("w_beat", {axi.wdata, axi.wstrb, axi.wlast}, {w.data, w.strb, w.last});
          end
        end
        if (axi.rvalid && !rsp_rdy) begin
          hold_seen++;
          check("rready_follows_rsp_rdy", axi.rready, 1'b0);
        end
        if (rsp_vld && rsp_rdy) begin
          rsp_seen++;
          if (rsp_exp.size() == 0) unexpected("rsp");
          else begin
            r = rsp_exp.pop_front();
            check("rsp_data", rsp_data, r);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test required end before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int w0;
    int n;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_rdy", cmd_rdy, 1'b0);
    check("rst_wd_rdy", wd_rdy, 1'b0);
    check("rst_awvalid", axi.awvalid, 1'b0);
    check("rst_wvalid", axi.wvalid, 1'b0);
    check("rst_bready", axi.bready, 1'b0);
    check("rst_arvalid", axi.arvalid, 1'b0);
    check("rst_rready", axi.rready, 1'b0);
    check("rst_rsp_vld", rsp_vld, 1'b0);
    check("rst_rsp_data", rsp_data, '0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_cmd_rdy", cmd_rdy, 1'b1);

    // single-beat write
    push_wr(4'd1, 32'h1000, 8'd0, 32'hDEADBEEF, AXI_RESP_OKAY, 4'd1, 1'b0);
    wait_rsp(1, "wr_len0");
    @(negedge clk);
    check("cmd_rdy_after_wrsp", cmd_rdy, 1'b1);

    // 4-beat write with gappy write data
    wd_gap = 1'b1;
    push_wr(4'd2, 32'h2000, 8'd3, 32'h11110000, AXI_RESP_OKAY, 4'd2, 1'b0);
    wait_rsp(2, "wr_len3_gaps");
    wd_gap = 1'b0;

    // 8-beat read with response backpressure after beat 3
    r_acc = 0; hold_seen = 0; hold_at = 3;
    push_rd(4'd3, 32'h3000, 8'd7, 8, 32'hA0000000, AXI_RESP_OKAY, 8'h00);
    wait_rsp(10, "rd_len7_hold");
    check("rsp_rdy_hold_cycles", 32'(hold_seen), 32'd5);
    hold_at = -1;

    // early rlast, then a normal read; then a read running past len; then a bid mismatch
    push_rd(4'd4, 32'h4000, 8'd3, 2, 32'hB0, AXI_RESP_OKAY, 8'b10);
    push_rd(4'd5, 32'h4100, 8'd0, 1, 32'hC0, AXI_RESP_OKAY, 8'b0);
    wait_rsp(13, "rd_short_then_next");
    push_rd(4'd6, 32'h4200, 8'd1, 3, 32'hD0, AXI_RESP_EXOKAY, 8'b110);
    wait_rsp(16, "rd_overlong");
    push_wr(4'd7, 32'h4300, 8'd0, 32'h77, AXI_RESP_OKAY, 4'd8, 1'b1);
    wait_rsp(17, "wr_bid_mismatch");

    // asynchronous reset in the middle of a write burst
    w0 = w_seen;
    push_wr(4'd9, 32'h5000, 8'd3, 32'h5500, AXI_RESP_OKAY, 4'd9, 1'b0);
    n = 0;
    while (w_seen < w0 + 2 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("reached_w_beat2", 32'(w_seen - w0), 32'd2);
    reset = 1'b1;
    #1;
    check("arst_awvalid", axi.awvalid, 1'b0);
    check("arst_wvalid", axi.wvalid, 1'b0);
    check("arst_wd_rdy", wd_rdy, 1'b0);
    check("arst_bready", axi.bready, 1'b0);
    check("arst_arvalid", axi.arvalid, 1'b0);
    check("arst_rready", axi.rready, 1'b0);
    check("arst_rsp_vld", rsp_vld, 1'b0);
    check("arst_cmd_rdy", cmd_rdy, 1'b0);
    clear_queues();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_wr(4'd10, 32'h6000, 8'd1, 32'h6600, AXI_RESP_OKAY, 4'd10, 1'b0);
    wait_rsp(18, "wr_after_reset");

    // fresh counters: three writes (one SLVERR) and two reads
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    push_wr(4'd1, 32'h7000, 8'd0, 32'h70, AXI_RESP_OKAY, 4'd1, 1'b0);
    push_wr(4'd2, 32'h7100, 8'd0, 32'h71, AXI_RESP_SLVERR, 4'd2, 1'b0);
    push_wr(4'd3, 32'h7200, 8'd0, 32'h72, AXI_RESP_OKAY, 4'd3, 1'b0);
    push_rd(4'd4, 32'h7300, 8'd1, 2, 32'hE0, AXI_RESP_OKAY, 8'b0);
    push_rd(4'd5, 32'h7400, 8'd0, 1, 32'hF0, AXI_RESP_OKAY, 8'b0);
    wait_rsp(24, "perf_mix");
    @(negedge clk);
`ifdef APB2AXI_PERF_CNT_EN
    check("perf_wr_cnt", perf_wr_cnt, 32'd3);
    check("perf_rd_cnt", perf_rd_cnt, 32'd2);
    check("perf_err_cnt", perf_err_cnt, 16'd1);
`endif
    check("expectations_drained",
          32'(aw_exp.size() + ar_exp.size() + w_exp.size() + rsp_exp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
